// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction prefetch stage.
// Optional feature macro used by fetch_queue: FETCH_QUEUE_BYPASS_EN.
package fetch_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // One buffered instruction together with the PC it was fetched from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Default first fetch address after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small instruction FIFO holding {pc, instr} entries.
// Head is read combinationally so a pushed entry is visible the cycle after
// the push. Synchronous clear empties the queue without touching storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;

  // Per-entry storage write; storage needs no reset since count gates validity
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clock) begin
      if (push && !clear && (wr_ptr_reg == AW'(gi))) begin
        mem[gi] <= push_entry;
      end
    end
  end

  // Pointer and occupancy update; clear wins over a same-cycle push/pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch with redirect/flush.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty and the core
// is ready, an acked word is forwarded straight to the core in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_rdata,
  output logic                    inst_valid,
  output logic [31:0]             inst_data,
  output logic [31:0]             inst_pc,
  input  logic                    inst_ready,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_t  state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   stale_addr_reg, stale_addr_next;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_clear;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          bypass;
  logic          accept;
  logic [CW:0]   occ_idle;
  logic [CW:0]   occ_after;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (fifo_clear),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

  assign push_entry = '{pc: fetch_pc_reg, instr: imem_rdata};
  assign count      = fifo_count;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (state_reg == REQ) && imem_ack && inst_ready && !redirect && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // A FIFO pop; a redirect in the same cycle cancels it (the queue is cleared)
  assign accept   = !fifo_empty && inst_ready && !redirect;
  assign fifo_pop = accept;

  // Core-facing outputs: FIFO head, or the acked word when bypassing
  always_comb begin
    inst_valid = !fifo_empty;
    inst_data  = fifo_empty ? 32'h0 : fifo_head.instr;
    inst_pc    = fifo_empty ? 32'h0 : fifo_head.pc;
    if (bypass) begin
      inst_valid = 1'b1;
      inst_data  = imem_rdata;
      inst_pc    = fetch_pc_reg;
    end
  end

  // Fetch FSM next-state, memory request and FIFO push/clear control
  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    stale_addr_next = stale_addr_reg;
    imem_req        = 1'b0;
    imem_addr       = fetch_pc_reg;
    fifo_push       = 1'b0;
    fifo_clear      = 1'b0;
    occ_idle        = {1'b0, fifo_count} + {{CW{1'b0}}, accept};
    occ_after       = {1'b0, fifo_count} + {{CW{1'b0}}, !bypass} - {{CW{1'b0}}, accept};

    case (state_reg)
      IDLE: begin
        // Only request once a slot can be reserved for the returning word
        if (occ_idle < DEPTH_W) state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          fifo_push     = !bypass;
          fetch_pc_next = fetch_pc_reg + 32'd4;
          if (occ_after >= DEPTH_W) state_next = IDLE;
        end
      end
      DROP: begin
        // Finish the stale request on its original address, then refetch
        imem_req  = 1'b1;
        imem_addr = stale_addr_reg;
        if (imem_ack) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase

    if (redirect) begin
      fifo_clear    = 1'b1;
      fifo_push     = 1'b0;
      fetch_pc_next = align_word(redirect_pc);
      case (state_reg)
        REQ: begin
          if (imem_ack) begin
            state_next = REQ;
          end else begin
            state_next      = DROP;
            stale_addr_next = fetch_pc_reg;
          end
        end
        // A stale request completing in this very cycle leaves nothing to drop
        DROP:    state_next = imem_ack ? REQ : DROP;
        default: state_next = REQ;
      endcase
    end
  end

  // FSM state, fetch PC and held stale address registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= RESET_PC;
      stale_addr_reg <= RESET_PC;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      stale_addr_reg <= stale_addr_next;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fill, drain, streaming, redirect,
// misaligned redirect, address wrap and asynchronous reset.
module tb_fetch_queue;

  localparam logic [31:0] K = 32'hA5A5_0F0F;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ack_tie = 1'b1;
  logic        ack_man = 1'b0;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic        imem_req, imem_ack, inst_valid;
  logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc;
  logic [2:0]  count;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_data, w_pc;
  logic [2:0]  w_count;

  int vectors = 0;
  int miscompares = 0;

  assign imem_ack   = ack_tie ? imem_req : ack_man;
  assign imem_rdata = imem_addr ^ K;

  always #5 clock = ~clock;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .count       (count)
  );

  // Second instance starting near the top of the address space
  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_ack    (w_req),
    .imem_rdata  (w_addr),
    .inst_valid  (w_valid),
    .inst_data   (w_data),
    .inst_pc     (w_pc),
    .inst_ready  (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .count       (w_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    // ---- reset values ----
    #2 reset = 1'b0;
    #1;
    chk("rst_req",   32'(imem_req),   32'h0);
    chk("rst_addr",  imem_addr,       32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_data",  inst_data,       32'h0);
    chk("rst_pc",    inst_pc,         32'h0);
    chk("rst_count", 32'(count),      32'h0);
    chk("rst_waddr", w_addr,          32'hFFFF_FFF8);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // ---- zero-wait fill, ack tied to req, core stalled ----
    for (int i = 0; i < 4; i++) begin
      chk("fill_req",   32'(imem_req), 32'h1);
      chk("fill_addr",  imem_addr,     32'(4 * i));
      chk("wrap_addr",  w_addr,        32'hFFFF_FFF8 + 32'(4 * i));
      @(negedge clock);
    end
    chk("full_req",   32'(imem_req),   32'h0);
    chk("full_count", 32'(count),      32'h4);
    chk("full_valid", 32'(inst_valid), 32'h1);
    chk("full_pc",    inst_pc,         32'h0);
    chk("wrap_count", 32'(w_count),    32'h4);
    chk("wrap_head",  w_pc,            32'hFFFF_FFF8);
    @(negedge clock);
    chk("hold_req",   32'(imem_req),   32'h0);

    // ---- drain in order; refill resumes at 0x10 ----
    inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_valid", 32'(inst_valid), 32'h1);
      chk("drain_pc",    inst_pc,         32'(4 * i));
      chk("drain_data",  inst_data,       32'(4 * i) ^ K);
      @(negedge clock);
    end

    // ---- streaming from reset ----
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("strm_valid0", 32'(inst_valid), 32'h0);
    chk("strm_addr0",  imem_addr,       32'h0);
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      chk("strm_valid", 32'(inst_valid), 32'h1);
      chk("strm_pc",    inst_pc,         32'(4 * i));
      chk("strm_count", 32'(count),      32'h1);
      @(negedge clock);
    end

    // ---- redirect with a stale request ----
    ack_tie    = 1'b0;
    ack_man    = 1'b0;
    inst_ready = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("stale_req",  32'(imem_req), 32'h1);
    chk("stale_addr", imem_addr,     32'h0);
    @(negedge clock);
    chk("stale_hold", imem_addr,     32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clock);
    redirect = 1'b0;
    chk("drop_req",   32'(imem_req), 32'h1);
    chk("drop_addr",  imem_addr,     32'h0);
    chk("drop_count", 32'(count),    32'h0);
    ack_man = 1'b1;
    @(negedge clock);
    ack_man = 1'b0;
    chk("rdir_count", 32'(count),      32'h0);
    chk("rdir_valid", 32'(inst_valid), 32'h0);
    chk("rdir_addr",  imem_addr,       32'h0000_0100);
    ack_man = 1'b1;
    @(negedge clock);
    ack_man = 1'b0;
    chk("rdir_pc",    inst_pc,    32'h0000_0100);
    chk("rdir_cnt1",  32'(count), 32'h1);

    // ---- redirect coincident with ack and pop, misaligned target ----
    ack_man     = 1'b1;
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    @(negedge clock);
    ack_man  = 1'b0;
    redirect = 1'b0;
    chk("coin_count", 32'(count),      32'h0);
    chk("coin_valid", 32'(inst_valid), 32'h0);
    chk("coin_pc",    inst_pc,         32'h0);
    chk("coin_data",  inst_data,       32'h0);
    chk("coin_addr",  imem_addr,       32'h0000_0200);
    ack_man = 1'b1;
    @(negedge clock);
    ack_man = 1'b0;
    chk("coin_pc1",   inst_pc,         32'h0000_0200);
    chk("coin_data1", inst_data,       32'h0000_0200 ^ K);
    @(negedge clock);
    chk("pop_count",  32'(count),      32'h0);
    chk("pop_addr",   imem_addr,       32'h0000_0204);

    // ---- asynchronous reset mid-REQ ----
    inst_ready = 1'b0;
    ack_man    = 1'b1;
    @(negedge clock);
    chk("pre_count",  32'(count), 32'h1);
    reset = 1'b0;
    #1;
    chk("arst_req",   32'(imem_req), 32'h0);
    chk("arst_count", 32'(count),    32'h0);
    chk("arst_addr",  imem_addr,     32'h0);
    @(negedge clock);
    chk("arst_ign",   32'(count),    32'h0);
    ack_man = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    chk("rel_req",    32'(imem_req), 32'h1);
    chk("rel_addr",   imem_addr,     32'h0);
    chk("rel_count",  32'(count),    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
